// File: rtl/regs_pkg.sv
// ============================================================================
//  Package : regs_pkg
//  Purpose : Register-file constants and writeback-source encoding shared by
//            the regfile, decode and the writeback arbiter.
//  Contents: XLEN, NREG, REG_ADDR_W, REG_ZERO, wb_src_e, is_reg_write()
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package regs_pkg;

  localparam int XLEN       = 32;
  localparam int NREG       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Which source owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EX   = 2'd1,
    GNT_LSU  = 2'd2
  } wb_src_e;

  // x0 is hardwired to zero: a handshake to it never produces a write.
  function automatic logic is_reg_write(input logic [REG_ADDR_W-1:0] rd);
    return rd != REG_ZERO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regs_scoreboard.sv
// ============================================================================
//  Module  : regs_scoreboard
//  Purpose : One pending bit per architectural register, marking registers
//            whose value is still owed by an outstanding load.
//  Ports   : clk, rst          - clock / synchronous active-high reset
//            set_en_i,set_rd_i - mark a register pending (load issued)
//            clr_en_i,clr_rd_i - release a register (load returned)
//            lk{a,b,c}_rd_i/_o - three combinational lookups of the
//                                registered pending state
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regs_scoreboard
  import regs_pkg::*;
#(
  parameter int NREG = regs_pkg::NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_rd_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_rd_i,
  input  logic [AW-1:0] lka_rd_i,
  input  logic [AW-1:0] lkb_rd_i,
  input  logic [AW-1:0] lkc_rd_i,
  output logic          lka_o,
  output logic          lkb_o,
  output logic          lkc_o
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Clear is applied before set so that a load issued in the same cycle as
  // an older load to the same register returns keeps ownership of it.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) pending_d[clr_rd_i] = 1'b0;
    if (set_en_i) pending_d[set_rd_i] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  // Lookups see only registered state: no bypass from this cycle's return.
  assign lka_o = pending_q[lka_rd_i];
  assign lkb_o = pending_q[lkb_rd_i];
  assign lkc_o = pending_q[lkc_rd_i];

endmodule

`default_nettype wire

// File: rtl/regs_wb_arbiter.sv
// ============================================================================
//  Module  : regs_wb_arbiter
//  Purpose : Shares the register file's single write port between execute
//            results (EX) and load returns (LSU), tracks in-flight load
//            destinations and stalls issue on RAW/WAW hazards against them.
//  Ports   : clk, rst                         clock / sync active-high reset
//            ex_valid/ex_ready/ex_rd/ex_data  EX writeback handshake
//            lsu_valid/lsu_ready/lsu_rd/lsu_data  load-return handshake
//            iss_valid/iss_load/iss_rs1/iss_rs2/iss_rd  issue lookup
//            iss_stall                        hold issue
//            wr_en/wr_addr/wr_data            register-file write port
//  Config  : WB_STARVE_GUARD_EN - when defined, EX is forced through after
//            MAX_WAIT consecutive lost cycles; otherwise LSU has strict
//            priority and EX may starve.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module regs_wb_arbiter
  import regs_pkg::*;
#(
  parameter int XLEN = regs_pkg::XLEN,
  parameter int NREG = regs_pkg::NREG
`ifdef WB_STARVE_GUARD_EN
  ,
  parameter int MAX_WAIT = 4
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ex_valid,
  output logic                    ex_ready,
  input  logic [$clog2(NREG)-1:0] ex_rd,
  input  logic [XLEN-1:0]         ex_data,
  input  logic                    lsu_valid,
  output logic                    lsu_ready,
  input  logic [$clog2(NREG)-1:0] lsu_rd,
  input  logic [XLEN-1:0]         lsu_data,
  input  logic                    iss_valid,
  input  logic                    iss_load,
  input  logic [$clog2(NREG)-1:0] iss_rs1,
  input  logic [$clog2(NREG)-1:0] iss_rs2,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  output logic                    iss_stall,
  output logic                    wr_en,
  output logic [$clog2(NREG)-1:0] wr_addr,
  output logic [XLEN-1:0]         wr_data
);

  localparam int AW = $clog2(NREG);

  wb_src_e w_gnt;
  logic    w_force_ex;
  logic    w_pend_rs1;
  logic    w_pend_rs2;
  logic    w_pend_rd;
  logic    w_set_en;

  // --------------------------------------------------------------------------
  // Optional starvation guard: counts consecutive cycles EX is kept waiting.
  // --------------------------------------------------------------------------
`ifdef WB_STARVE_GUARD_EN
  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  logic [WCW-1:0] wait_cnt_q;
  logic [WCW-1:0] wait_cnt_d;

  // The count can never pass WAIT_LIMIT: reaching it forces a grant, which
  // clears it on the following edge.
  assign w_force_ex = ex_valid & (wait_cnt_q == WAIT_LIMIT);

  always_comb begin
    wait_cnt_d = '0;
    if (ex_valid && (w_gnt != GNT_EX)) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wait_cnt_q <= '0;
    else     wait_cnt_q <= wait_cnt_d;
  end
`else
  assign w_force_ex = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Grant: LSU first unless EX is being forced through; nothing during reset.
  // --------------------------------------------------------------------------
  always_comb begin
    w_gnt = GNT_NONE;
    if (rst)             w_gnt = GNT_NONE;
    else if (w_force_ex) w_gnt = GNT_EX;
    else if (lsu_valid)  w_gnt = GNT_LSU;
    else if (ex_valid)   w_gnt = GNT_EX;
  end

  assign ex_ready  = (w_gnt == GNT_EX);
  assign lsu_ready = (w_gnt == GNT_LSU);

  // --------------------------------------------------------------------------
  // Write-port mux. Address/data follow the granted source even for x0 so the
  // port reflects the handshake; only the enable is suppressed.
  // --------------------------------------------------------------------------
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (w_gnt)
      GNT_EX: begin
        wr_en   = is_reg_write(REG_ADDR_W'(ex_rd));
        wr_addr = ex_rd;
        wr_data = ex_data;
      end
      GNT_LSU: begin
        wr_en   = is_reg_write(REG_ADDR_W'(lsu_rd));
        wr_addr = lsu_rd;
        wr_data = lsu_data;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Load scoreboard and issue hazard check.
  // --------------------------------------------------------------------------
  assign iss_stall = rst | (iss_valid & (w_pend_rs1 | w_pend_rs2 | w_pend_rd));
  assign w_set_en  = iss_valid & ~iss_stall & iss_load & (iss_rd != '0);

  regs_scoreboard #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en_i (w_set_en),
    .set_rd_i (iss_rd),
    .clr_en_i (lsu_ready),
    .clr_rd_i (lsu_rd),
    .lka_rd_i (iss_rs1),
    .lkb_rd_i (iss_rs2),
    .lkc_rd_i (iss_rd),
    .lka_o    (w_pend_rs1),
    .lkb_o    (w_pend_rs2),
    .lkc_o    (w_pend_rd)
  );

endmodule

`default_nettype wire

// File: tb/tb_regs_wb_arbiter.sv
// ============================================================================
//  Module  : tb_regs_wb_arbiter
//  Purpose : Self-checking bench for regs_wb_arbiter: directed scenarios
//            followed by randomized traffic against a behavioural model.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regs_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        lsu_valid, lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        iss_valid, iss_load;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd;
  logic        iss_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  always #5 clk = ~clk;

  regs_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_rd     (ex_rd),
    .ex_data   (ex_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .iss_valid (iss_valid),
    .iss_load  (iss_load),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .iss_stall (iss_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: the set of registers owed by outstanding loads,
  // and how many cycles in a row EX has been refused.
  bit pend [32];
  int ex_losses;
  bit last_exr, last_lsr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare all outputs with the model for the current inputs, then advance
  // the model to what the coming posedge must produce.
  task automatic step();
    bit          e_exr, e_lsr, e_wen, e_stall, force_ex;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    #1;
    e_exr = 0; e_lsr = 0; e_wen = 0; e_addr = '0; e_data = '0; e_stall = 1;
    if (!rst) begin
      force_ex = 0;
`ifdef WB_STARVE_GUARD_EN
      force_ex = ex_valid && (ex_losses >= 4);
`endif
      e_lsr = lsu_valid && !force_ex;
      e_exr = ex_valid && !e_lsr;
      if (e_lsr) begin
        e_addr = lsu_rd; e_data = lsu_data; e_wen = (lsu_rd != 0);
      end else if (e_exr) begin
        e_addr = ex_rd; e_data = ex_data; e_wen = (ex_rd != 0);
      end
      e_stall = iss_valid && (pend[iss_rs1] || pend[iss_rs2] || pend[iss_rd]);
    end
    check("ex_ready",  64'(ex_ready),  64'(e_exr));
    check("lsu_ready", 64'(lsu_ready), 64'(e_lsr));
    check("wr_en",     64'(wr_en),     64'(e_wen));
    check("wr_addr",   64'(wr_addr),   64'(e_addr));
    check("wr_data",   64'(wr_data),   64'(e_data));
    check("iss_stall", 64'(iss_stall), 64'(e_stall));
    if (rst) begin
      foreach (pend[i]) pend[i] = 0;
      ex_losses = 0;
    end else begin
      if (e_lsr) pend[lsu_rd] = 0;
      if (iss_valid && !e_stall && iss_load && iss_rd != 0) pend[iss_rd] = 1;
      ex_losses = (ex_valid && !e_exr) ? ex_losses + 1 : 0;
    end
    last_exr = e_exr;
    last_lsr = e_lsr;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_rd = '0; ex_data = '0;
    lsu_valid = 0; lsu_rd = '0; lsu_data = '0;
    iss_valid = 0; iss_load = 0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
  endtask

  initial begin
    int pl [$];
    bit exp_ex;
    foreach (pend[i]) pend[i] = 0;
    ex_losses = 0;
    idle_inputs();

    // 1: reset held with both sources requesting.
    rst = 1; ex_valid = 1; lsu_valid = 1; iss_valid = 1;
    ex_rd = 5'd1; lsu_rd = 5'd2; ex_data = 32'h11; lsu_data = 32'h22;
    #1;
    check("rst_wr_en",     64'(wr_en),     64'd0);
    check("rst_ex_ready",  64'(ex_ready),  64'd0);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd0);
    check("rst_iss_stall", 64'(iss_stall), 64'd1);
    step();
    step();
    rst = 0;
    idle_inputs();
    step();

    // 2: EX alone writes in the same cycle.
    ex_valid = 1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
    #1;
    check("t2_ex_ready", 64'(ex_ready), 64'd1);
    check("t2_wr_en",    64'(wr_en),    64'd1);
    check("t2_wr_addr",  64'(wr_addr),  64'd5);
    check("t2_wr_data",  64'(wr_data),  64'hDEADBEEF);
    step();
    ex_valid = 0;

    // 3: both valid, LSU first, EX the cycle after.
    ex_valid = 1; ex_rd = 5'd3; ex_data = 32'h3333;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h4444;
    #1;
    check("t3_lsu_ready", 64'(lsu_ready), 64'd1);
    check("t3_ex_ready",  64'(ex_ready),  64'd0);
    check("t3_wr_addr",   64'(wr_addr),   64'd4);
    step();
    lsu_valid = 0;
    #1;
    check("t3_ex_ready2", 64'(ex_ready), 64'd1);
    check("t3_wr_addr2",  64'(wr_addr),  64'd3);
    step();
    ex_valid = 0;

    // 4: load rd=7, then a consumer of x7 stalls until after the return.
    iss_valid = 1; iss_load = 1; iss_rd = 5'd7; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    step();
    iss_load = 0; iss_rs1 = 5'd7; iss_rd = 5'd8;
    #1;
    check("t4_stall_a", 64'(iss_stall), 64'd1);
    step();
    step();
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h7777;
    #1;
    check("t4_stall_ret", 64'(iss_stall), 64'd1);
    step();
    lsu_valid = 0;
    #1;
    check("t4_stall_free", 64'(iss_stall), 64'd0);
    step();

    // 5: return to x7 (not pending) while a new load to x7 issues.
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'h7070;
    iss_valid = 1; iss_load = 1; iss_rd = 5'd7; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    #1;
    check("t5_issue_ok", 64'(iss_stall), 64'd0);
    step();
    lsu_valid = 0; iss_load = 0; iss_rs1 = 5'd7; iss_rd = 5'd9;
    #1;
    check("t5_stall_kept", 64'(iss_stall), 64'd1);
    step();
    iss_valid = 0; lsu_valid = 1; lsu_rd = 5'd7;
    step();
    lsu_valid = 0;

    // 6: continuous contention, then an EX handshake to x0.
    ex_valid = 1; ex_rd = 5'd9; ex_data = 32'h9999;
    lsu_valid = 1; lsu_rd = 5'd10; lsu_data = 32'hAAAA;
    for (int i = 0; i < 10; i++) begin
`ifdef WB_STARVE_GUARD_EN
      exp_ex = ((i % 5) == 4);
`else
      exp_ex = 0;
`endif
      #1;
      check("t6_ex_ready", 64'(ex_ready), 64'(exp_ex));
      step();
    end
    lsu_valid = 0; ex_rd = 5'd0;
    #1;
    check("t6_x0_ready", 64'(ex_ready), 64'd1);
    check("t6_x0_wr_en", 64'(wr_en),    64'd0);
    step();
    idle_inputs();
    step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!ex_valid && $urandom_range(0, 1) == 1) begin
        ex_valid = 1; ex_rd = 5'($urandom_range(0, 31)); ex_data = $urandom;
      end
      if (!lsu_valid && $urandom_range(0, 9) < 4) begin
        pl.delete();
        foreach (pend[i]) if (pend[i]) pl.push_back(i);
        lsu_valid = 1; lsu_data = $urandom;
        if (pl.size() > 0 && $urandom_range(0, 4) != 0)
          lsu_rd = 5'(pl[$urandom_range(0, pl.size() - 1)]);
        else
          lsu_rd = 5'($urandom_range(0, 31));
      end
      iss_valid = ($urandom_range(0, 9) < 7);
      iss_load  = ($urandom_range(0, 9) < 4);
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      step();
      if (last_exr || rst) ex_valid = 0;
      if (last_lsr || rst) lsu_valid = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
